arp_rx_parser: RTL and testbench
================================

# arp_rx_parser

Parametrised ARP receive parser on the 8-bit RX MAC AXI-Stream, in the `rx_mac_aclk` domain. It validates every ARP header field and filters on a runtime-programmable local IP and MAC. Qualified requests (and optionally replies) are queued as events in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake, for the ARP TX responder and the ARP cache. Saturating statistics counters report accepted requests, accepted replies, FIFO overflows and errored frames.

## Interface
- FIFO_DEPTH, 4, event FIFO depth; power of two, 2..16
- CHECK_DMAC, 1, 1 = Ethernet DMAC must be broadcast or `local_mac`; 0 = DMAC ignored
- ACCEPT_REPLY, 1, 1 = ARP replies (OPER 2) also produce events; 0 = requests only
- rx_mac_aclk  in  1  clock
- rx_mac_reset  in  1  reset rx_mac_reset, asynchronous, active-high; clock rx_mac_aclk
- local_ip  in  32  local IPv4 address; quasi-static
- local_mac  in  48  local MAC address; quasi-static
- rx_axis_mac_tdata  in  8  frame byte, DMAC first, FCS already stripped
- rx_axis_mac_tvalid  in  1  byte valid; no tready, every valid beat is consumed
- rx_axis_mac_tlast  in  1  last byte of frame
- rx_axis_mac_tuser  in  1  frame error, meaningful on the tlast beat only
- m_arp_tvalid  out  1  event available
- m_arp_tready  in  1  consumer accepts event
- m_arp_is_reply  out  1  0 = request, 1 = reply
- m_arp_smac  out  48  ARP sender hardware address (SHA)
- m_arp_sip  out  32  ARP sender protocol address (SPA)
- stat_req_cnt  out  16  requests queued
- stat_rep_cnt  out  16  replies queued
- stat_drop_cnt  out  16  qualified frames lost because the FIFO was full
- stat_err_cnt  out  16  frames ending with tuser=1 (any ethertype)

## Operation
- 11-bit byte index: 0 on the first valid beat of a frame. Increments per valid beat and saturates at 2047. Returns to 0 after the tlast beat. Cycles with tvalid=0 change nothing.
- Byte offsets and checks:
  - 0-5: DMAC; with CHECK_DMAC=1 it must equal FF:FF:FF:FF:FF:FF or `local_mac`.
  - 6-11: Ethernet SMAC, not checked.
  - 12-13: ethertype = 0x0806.
  - 14-15: HTYPE = 0x0001.
  - 16-17: PTYPE = 0x0800.
  - 18: HLEN = 6.
  - 19: PLEN = 4.
  - 20-21: OPER = 0x0001, or 0x0002 only when ACCEPT_REPLY=1.
  - 22-27: SHA, captured.
  - 28-31: SPA, captured.
  - 32-37: THA, ignored.
  - 38-41: TPA, must equal `local_ip`.
- Each field is checked as its last byte arrives; DMAC is checked at byte 5.
- States:
  - S_PARSE: reset state. Counts and checks bytes. Any mismatch -> S_DISCARD, or straight back to S_PARSE with index 0 if that beat is tlast.
  - S_DISCARD: ignores bytes until the tlast beat, then -> S_PARSE with index 0.
- A frame qualifies when all of the following hold on its tlast beat:
  - state is S_PARSE;
  - byte index ≥ 41;
  - tuser = 0.
- Runts (tlast before byte 41) never qualify. Padding and trailing bytes after byte 41 are ignored.
- `local_ip` and `local_mac` are compared at the byte where the check happens. Changing them mid-frame gives an undefined result for that frame only.
- Qualification registers a commit strobe along with is_reply, SHA and SPA. On the next edge the event is written to the FIFO.
- Write when full:
  - if m_arp_tready=1 on that same cycle, the write succeeds because the pop frees the slot;
  - otherwise the event is discarded and stat_drop_cnt increments.
- A successful write increments stat_req_cnt or stat_rep_cnt. Any tlast beat with tuser=1 increments stat_err_cnt.
- All counters saturate at 0xFFFF and clear only on reset.
- FIFO is FWFT. m_arp_* fields hold steady while tvalid=1 and tready=0. A pop happens when tvalid and tready are both 1.

## Timing
- Reset values: all outputs 0, FIFO empty, state S_PARSE, byte index 0.
- Latency: tlast beat sampled at edge N -> commit at N -> FIFO write at N+1 -> m_arp_tvalid=1 after edge N+1, with the FIFO previously empty.
- Back-to-back frames (tlast, then byte 0 on the next cycle) are fully supported. Consecutive commits are at least 42 cycles apart, so only one write is ever pending.
- Reset mid-frame: all state clears immediately and queued events are lost. Upstream guarantees that reset deasserts between frames.
- tvalid gaps of any length inside a frame do not affect parsing or latency, which is measured from the tlast beat.

## Test plan
- Basic request: local_ip=C0A80101; broadcast request with SHA 00:11:22:33:44:55, SPA C0A80164, TPA C0A80101, 18 pad bytes. Expect one event 2 cycles after tlast: is_reply=0, smac=001122334455, sip=C0A80164, stat_req_cnt=1.
- Wrong target: same frame with TPA C0A80102, then a frame with HLEN=8, then an IPv4 frame (0x0800). Expect no events and all counters 0.
- Errored frame: valid request with tuser=1 on tlast. Expect no event and stat_err_cnt=1.
- Replies and DMAC filter, ACCEPT_REPLY=1, CHECK_DMAC=1:
  - reply to local_mac=02:00:00:00:00:01 -> event with is_reply=1, stat_rep_cnt=1;
  - same reply to DMAC 02:00:00:00:00:09 -> no event.
- Overflow: hold tready=0, send FIFO_DEPTH+2 valid requests with SPA .101, .102, and so on. Expect stat_drop_cnt=2; on release, exactly FIFO_DEPTH events pop in order .101 upward. Then a push coinciding with a pop while full -> no drop.
- Reset and gaps: assert reset at byte 20 of a request; outputs read 0. Then send a valid request with random tvalid gaps. Expect exactly one correct event.

Source files
------------

// File: rtl/arp_rx_parser_if.sv
// Bundles the RX MAC byte stream and the ARP event handshake of arp_rx_parser.
// The master side is the parser; the slave side is the MAC plus event consumer.
interface arp_rx_parser_if;
    logic [7:0]  rx_axis_mac_tdata;
    logic        rx_axis_mac_tvalid;
    logic        rx_axis_mac_tlast;
    logic        rx_axis_mac_tuser;

    logic        m_arp_tvalid;
    logic        m_arp_tready;
    logic        m_arp_is_reply;
    logic [47:0] m_arp_smac;
    logic [31:0] m_arp_sip;

    modport master (
        input  rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
        input  m_arp_tready,
        output m_arp_tvalid, m_arp_is_reply, m_arp_smac, m_arp_sip
    );

    modport slave (
        output rx_axis_mac_tdata, rx_axis_mac_tvalid, rx_axis_mac_tlast, rx_axis_mac_tuser,
        output m_arp_tready,
        input  m_arp_tvalid, m_arp_is_reply, m_arp_smac, m_arp_sip
    );
endinterface

// File: rtl/arp_rx_parser.sv
// ARP receive parser: validates Ethernet/ARP header bytes, filters on local IP/MAC,
// and queues qualified request/reply events in a small FWFT FIFO with statistics.
module arp_rx_parser #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          CHECK_DMAC   = 1'b1,
    parameter bit          ACCEPT_REPLY = 1'b1
) (
    input  logic                  rx_mac_aclk,
    input  logic                  rx_mac_reset,
    input  logic [31:0]           local_ip,
    input  logic [47:0]           local_mac,
    arp_rx_parser_if.master       bus,
    output logic [15:0]           stat_req_cnt,
    output logic [15:0]           stat_rep_cnt,
    output logic [15:0]           stat_drop_cnt,
    output logic [15:0]           stat_err_cnt
);

    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam int unsigned EW      = 1 + 48 + 32;

    typedef enum logic {S_PARSE, S_DISCARD} state_t;

    state_t        state_q, state_d;
    logic [10:0]   idx_q, idx_d;
    logic [39:0]   sh_q, sh_d;
    logic          is_reply_q, is_reply_d;
    logic [47:0]   sha_q, sha_d;
    logic [31:0]   spa_q, spa_d;
    logic          commit_q, commit_d;

    logic [EW-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [15:0]   req_cnt_q, req_cnt_d;
    logic [15:0]   rep_cnt_q, rep_cnt_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic          beat;
    logic          field_bad;
    logic [47:0]   cur48;
    logic          fifo_valid;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] entry_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    assign beat  = bus.rx_axis_mac_tvalid;
    // Multi-byte fields are compared once their last byte arrives, using the
    // previously shifted bytes concatenated with the current one.
    assign cur48 = {sh_q, bus.rx_axis_mac_tdata};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sh_d       = sh_q;
        is_reply_d = is_reply_q;
        sha_d      = sha_q;
        spa_d      = spa_q;
        commit_d   = 1'b0;
        field_bad  = 1'b0;

        if (beat) begin
            sh_d  = cur48[39:0];
            idx_d = bus.rx_axis_mac_tlast ? '0 :
                    ((idx_q == 11'd2047) ? idx_q : idx_q + 11'd1);

            if (state_q == S_PARSE) begin
                case (idx_q)
                    11'd5:  if (CHECK_DMAC && !(cur48 == '1 || cur48 == local_mac)) field_bad = 1'b1;
                    11'd13: if (cur48[15:0] != 16'h0806) field_bad = 1'b1;
                    11'd15: if (cur48[15:0] != 16'h0001) field_bad = 1'b1;
                    11'd17: if (cur48[15:0] != 16'h0800) field_bad = 1'b1;
                    11'd18: if (bus.rx_axis_mac_tdata != 8'd6) field_bad = 1'b1;
                    11'd19: if (bus.rx_axis_mac_tdata != 8'd4) field_bad = 1'b1;
                    11'd21: begin
                        if (cur48[15:0] == 16'h0001)                      is_reply_d = 1'b0;
                        else if (ACCEPT_REPLY && cur48[15:0] == 16'h0002) is_reply_d = 1'b1;
                        else                                              field_bad  = 1'b1;
                    end
                    11'd27: sha_d = cur48;
                    11'd31: spa_d = cur48[31:0];
                    11'd41: if (cur48[31:0] != local_ip) field_bad = 1'b1;
                    default: ;
                endcase

                if (field_bad) begin
                    state_d = bus.rx_axis_mac_tlast ? S_PARSE : S_DISCARD;
                end else if (bus.rx_axis_mac_tlast && idx_q >= 11'd41 && !bus.rx_axis_mac_tuser) begin
                    commit_d = 1'b1;
                end
            end else if (bus.rx_axis_mac_tlast) begin
                state_d = S_PARSE;
            end
        end
    end

    // The committed fields stay stable for the write cycle: the next frame
    // cannot reach its OPER/SHA/SPA bytes within one cycle of tlast.
    always_comb begin
        fifo_valid = (count_q != '0);
        fifo_full  = (count_q == DEPTH_C);
        pop        = fifo_valid && bus.m_arp_tready;
        push       = commit_q && (!fifo_full || pop);
        drop       = commit_q && fifo_full && !pop;
        entry_d    = {is_reply_q, sha_q, spa_q};

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        req_cnt_d  = (push && !is_reply_q) ? sat_inc(req_cnt_q) : req_cnt_q;
        rep_cnt_d  = (push &&  is_reply_q) ? sat_inc(rep_cnt_q) : rep_cnt_q;
        drop_cnt_d = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
        err_cnt_d  = (beat && bus.rx_axis_mac_tlast && bus.rx_axis_mac_tuser) ?
                     sat_inc(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
        if (rx_mac_reset) begin
            state_q    <= S_PARSE;
            idx_q      <= '0;
            sh_q       <= '0;
            is_reply_q <= 1'b0;
            sha_q      <= '0;
            spa_q      <= '0;
            commit_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            req_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
            fifo_mem_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sh_q       <= sh_d;
            is_reply_q <= is_reply_d;
            sha_q      <= sha_d;
            spa_q      <= spa_d;
            commit_q   <= commit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            req_cnt_q  <= req_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
            if (push) fifo_mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign bus.m_arp_tvalid = fifo_valid;
    assign {bus.m_arp_is_reply, bus.m_arp_smac, bus.m_arp_sip} = fifo_mem_q[rd_ptr_q];

    assign stat_req_cnt  = req_cnt_q;
    assign stat_rep_cnt  = rep_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
    assign stat_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Directed bench for arp_rx_parser: a table of single-frame vectors plus
// hand-written overflow, push-while-full, reset and tvalid-gap sequences.
module tb_arp_rx_parser;

    localparam int unsigned DEPTH = 4;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] LMAC  = 48'h0200_0000_0001;
    localparam logic [31:0] LIP   = 32'hC0A8_0101;
    localparam logic [47:0] SHA1  = 48'h0011_2233_4455;

    typedef struct {
        logic [47:0] dmac;
        logic [15:0] etype;
        logic [7:0]  hlen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [31:0] tpa;
        int          len;
        bit          tuser;
        bit          exp_ev;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] local_ip  = LIP;
    logic [47:0] local_mac = LMAC;
    logic [15:0] req_cnt, rep_cnt, drop_cnt, err_cnt;

    arp_rx_parser_if bus();

    arp_rx_parser #(.FIFO_DEPTH(DEPTH), .CHECK_DMAC(1'b1), .ACCEPT_REPLY(1'b1)) dut (
        .rx_mac_aclk   (clk),
        .rx_mac_reset  (rst),
        .local_ip      (local_ip),
        .local_mac     (local_mac),
        .bus           (bus),
        .stat_req_cnt  (req_cnt),
        .stat_rep_cnt  (rep_cnt),
        .stat_drop_cnt (drop_cnt),
        .stat_err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_req = 0, exp_rep = 0, exp_drop = 0, exp_err = 0;
    logic [7:0] fb [0:127];
    vec_t vecs [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [47:0] d, input logic [15:0] et, input logic [7:0] hl,
                                input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                                input logic [31:0] tpa, input int len, input bit tu, input bit ev);
        vec_t v;
        v.dmac = d; v.etype = et; v.hlen = hl; v.oper = op; v.sha = sha;
        v.spa = spa; v.tpa = tpa; v.len = len; v.tuser = tu; v.exp_ev = ev;
        return v;
    endfunction

    task automatic build(input vec_t v);
        logic [47:0] smac;
        smac = 48'h0A0B_0C0D_0E0F;
        for (int i = 0; i < 128; i++) fb[i] = 8'h00;
        for (int k = 0; k < 6; k++) begin
            fb[k]      = v.dmac[47-8*k -: 8];
            fb[6+k]    = smac[47-8*k -: 8];
            fb[22+k]   = v.sha[47-8*k -: 8];
        end
        fb[12] = v.etype[15:8]; fb[13] = v.etype[7:0];
        fb[14] = 8'h00;         fb[15] = 8'h01;
        fb[16] = 8'h08;         fb[17] = 8'h00;
        fb[18] = v.hlen;        fb[19] = 8'h04;
        fb[20] = v.oper[15:8];  fb[21] = v.oper[7:0];
        for (int k = 0; k < 4; k++) begin
            fb[28+k] = v.spa[31-8*k -: 8];
            fb[38+k] = v.tpa[31-8*k -: 8];
        end
    endtask

    // Returns #1 after the edge that samples the tlast beat (or after reset is raised).
    task automatic send(input int len, input bit tu, input bit gaps, input int rst_at);
        for (int i = 0; i < len; i++) begin
            if (i == rst_at) begin
                bus.rx_axis_mac_tvalid = 1'b0;
                rst = 1'b1;
                return;
            end
            if (gaps && i > 0) begin
                int g;
                g = int'($urandom_range(0, 3));
                bus.rx_axis_mac_tvalid = 1'b0;
                for (int j = 0; j < g; j++) begin
                    @(posedge clk); #1;
                end
            end
            bus.rx_axis_mac_tvalid = 1'b1;
            bus.rx_axis_mac_tdata  = fb[i];
            bus.rx_axis_mac_tlast  = (i == len - 1);
            bus.rx_axis_mac_tuser  = tu && (i == len - 1);
            @(posedge clk); #1;
        end
        bus.rx_axis_mac_tvalid = 1'b0;
        bus.rx_axis_mac_tlast  = 1'b0;
        bus.rx_axis_mac_tuser  = 1'b0;
    endtask

    task automatic pop_one();
        bus.m_arp_tready = 1'b1;
        @(posedge clk); #1;
        bus.m_arp_tready = 1'b0;
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".req"},  64'(req_cnt),  64'(exp_req));
        chk({tag, ".rep"},  64'(rep_cnt),  64'(exp_rep));
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(exp_drop));
        chk({tag, ".err"},  64'(err_cnt),  64'(exp_err));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_axis_mac_tdata  = 8'h00;
        bus.rx_axis_mac_tvalid = 1'b0;
        bus.rx_axis_mac_tlast  = 1'b0;
        bus.rx_axis_mac_tuser  = 1'b0;
        bus.m_arp_tready       = 1'b0;

        vecs[0]  = mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80164, LIP, 60, 1'b0, 1'b1);
        vecs[1]  = mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80164, 32'hC0A80102, 60, 1'b0, 1'b0);
        vecs[2]  = mk(BCAST, 16'h0806, 8'd8, 16'd1, SHA1, 32'hC0A80164, LIP, 60, 1'b0, 1'b0);
        vecs[3]  = mk(BCAST, 16'h0800, 8'd6, 16'd1, SHA1, 32'hC0A80164, LIP, 60, 1'b0, 1'b0);
        vecs[4]  = mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80164, LIP, 60, 1'b1, 1'b0);
        vecs[5]  = mk(LMAC,  16'h0806, 8'd6, 16'd2, 48'hAABB_CCDD_EEFF, 32'hC0A80105, LIP, 60, 1'b0, 1'b1);
        vecs[6]  = mk(48'h0200_0000_0009, 16'h0806, 8'd6, 16'd2, 48'hAABB_CCDD_EEFF, 32'hC0A80105, LIP, 60, 1'b0, 1'b0);
        vecs[7]  = mk(LMAC,  16'h0806, 8'd6, 16'd1, 48'h1234_5678_9ABC, 32'h0A000001, LIP, 42, 1'b0, 1'b1);
        vecs[8]  = mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80164, LIP, 41, 1'b0, 1'b0);
        vecs[9]  = mk(BCAST, 16'h0806, 8'd6, 16'd3, SHA1, 32'hC0A80164, LIP, 60, 1'b0, 1'b0);
        vecs[10] = mk(48'hFFFF_FFFF_FFFE, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80164, LIP, 60, 1'b0, 1'b0);
        vecs[11] = mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80164, LIP, 42, 1'b1, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.tvalid", 64'(bus.m_arp_tvalid), 64'd0);
        chk("rst.smac",   64'(bus.m_arp_smac),   64'd0);
        chk("rst.sip",    64'(bus.m_arp_sip),    64'd0);
        chk_counters("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[n]) begin
            string tag;
            tag = $sformatf("v%0d", n);
            build(vecs[n]);
            send(vecs[n].len, vecs[n].tuser, 1'b0, -1);
            chk({tag, ".lat1"}, 64'(bus.m_arp_tvalid), 64'd0);
            @(posedge clk); #1;
            chk({tag, ".ev"}, 64'(bus.m_arp_tvalid), 64'(vecs[n].exp_ev));
            if (vecs[n].exp_ev) begin
                chk({tag, ".reply"}, 64'(bus.m_arp_is_reply), 64'(vecs[n].oper == 16'd2));
                chk({tag, ".smac"},  64'(bus.m_arp_smac),     64'(vecs[n].sha));
                chk({tag, ".sip"},   64'(bus.m_arp_sip),      64'(vecs[n].spa));
                pop_one();
                chk({tag, ".empty"}, 64'(bus.m_arp_tvalid), 64'd0);
                if (vecs[n].oper == 16'd2) exp_rep++; else exp_req++;
            end
            if (vecs[n].tuser) exp_err++;
            chk_counters(tag);
            repeat (2) @(posedge clk);
            #1;
        end

        // Overflow: DEPTH+2 back-to-back requests with no consumer.
        for (int i = 0; i < DEPTH + 2; i++) begin
            build(mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A80165 + 32'(i), LIP, 60, 1'b0, 1'b1));
            send(60, 1'b0, 1'b0, -1);
        end
        repeat (2) @(posedge clk);
        #1;
        exp_req += DEPTH; exp_drop += 2;
        chk_counters("ovf");
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ovf.v%0d", i),   64'(bus.m_arp_tvalid), 64'd1);
            chk($sformatf("ovf.sip%0d", i), 64'(bus.m_arp_sip),    64'(32'hC0A80165 + 32'(i)));
            pop_one();
        end
        chk("ovf.empty", 64'(bus.m_arp_tvalid), 64'd0);

        // Fill the FIFO, then let the 5th write coincide with a pop.
        for (int i = 0; i < DEPTH + 1; i++) begin
            build(mk(BCAST, 16'h0806, 8'd6, 16'd1, SHA1, 32'hC0A800C9 + 32'(i), LIP, 60, 1'b0, 1'b1));
            send(60, 1'b0, 1'b0, -1);
        end
        bus.m_arp_tready = 1'b1;
        @(posedge clk); #1;
        bus.m_arp_tready = 1'b0;
        exp_req += DEPTH + 1;
        chk_counters("pwf");
        for (int i = 1; i <= DEPTH; i++) begin
            chk($sformatf("pwf.v%0d", i),   64'(bus.m_arp_tvalid), 64'd1);
            chk($sformatf("pwf.sip%0d", i), 64'(bus.m_arp_sip),    64'(32'hC0A800C9 + 32'(i)));
            pop_one();
        end
        chk("pwf.empty", 64'(bus.m_arp_tvalid), 64'd0);

        // Queue one event, then reset in the middle of the next frame.
        build(vecs[0]);
        send(60, 1'b0, 1'b0, -1);
        repeat (2) @(posedge clk);
        #1;
        chk("prerst.tvalid", 64'(bus.m_arp_tvalid), 64'd1);
        send(60, 1'b0, 1'b0, 20);
        #1;
        exp_req = 0; exp_rep = 0; exp_drop = 0; exp_err = 0;
        chk("midrst.tvalid", 64'(bus.m_arp_tvalid),   64'd0);
        chk("midrst.reply",  64'(bus.m_arp_is_reply), 64'd0);
        chk("midrst.smac",   64'(bus.m_arp_smac),     64'd0);
        chk("midrst.sip",    64'(bus.m_arp_sip),      64'd0);
        chk_counters("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Valid request with random tvalid gaps.
        build(mk(BCAST, 16'h0806, 8'd6, 16'd1, 48'h0102_0304_0506, 32'hC0A80177, LIP, 60, 1'b0, 1'b1));
        send(60, 1'b0, 1'b1, -1);
        chk("gap.lat1", 64'(bus.m_arp_tvalid), 64'd0);
        @(posedge clk); #1;
        chk("gap.ev",   64'(bus.m_arp_tvalid), 64'd1);
        chk("gap.smac", 64'(bus.m_arp_smac),   64'h0102_0304_0506);
        chk("gap.sip",  64'(bus.m_arp_sip),    64'hC0A80177);
        pop_one();
        repeat (3) @(posedge clk);
        #1;
        chk("gap.single", 64'(bus.m_arp_tvalid), 64'd0);
        exp_req = 1;
        chk_counters("gap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
